unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Arbitrates requests, latches the granted address and data, and sequences the memory command.
- Returns read data and a one-cycle valid pulse to the granted requester.
- Drives per-requester stall requests into the stall unit so the pipeline freezes while an access is pending.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, cycles from the m_ce cycle to valid m_rdata. Legal range ≥1; 0 is illegal.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-high reset. 1 = reset.
- i_req  in  1  fetch request; held high until i_valid.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched instruction; meaningful only while i_valid=1.
- i_valid  out  1  one-cycle completion pulse for fetch.
- i_stall_req  out  1  combinational: i_req & ~i_valid.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; meaningful only while d_valid=1.
- d_valid  out  1  one-cycle completion pulse for data.
- d_stall_req  out  1  combinational: d_req & ~d_valid.
- m_ce  out  1  memory command strobe; exactly one cycle per transaction.
- m_we  out  1  memory write enable; only high together with m_ce.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; valid MEM_LAT cycles after m_ce.

Behaviour:
- Reset
  - Every registered output goes to 0: m_ce, m_we, m_addr, m_wdata, i_valid, d_valid, i_rdata, d_rdata.
  - State goes to IDLE; last_grant goes to I, so D wins the first tie.
  - Reset mid-transaction aborts it: the in-flight result is discarded and no valid pulse is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Samples requests.
  - Only i_req → grant I. Only d_req → grant D.
  - Both → round-robin: grant the opposite of last_grant.
  - On grant: latch owner, address, we (forced 0 for I) and wdata; update last_grant; go to ISSUE.
  - No request → stay in IDLE.
- ISSUE (1 cycle)
  - m_ce=1, m_we=latched we, m_addr/m_wdata from latches.
  - Write → RESP. Read → WAIT with counter loaded to MEM_LAT-1.
- WAIT
  - Counter decrements each cycle.
  - On the cycle where the count is 0, m_rdata is valid: capture it into the owner's rdata register and go to RESP.
  - With MEM_LAT=1, WAIT lasts exactly 1 cycle.
- RESP (1 cycle)
  - Owner's valid=1, rdata held.
  - Requests are ignored in this cycle, because the requester drops or changes its request only after seeing valid.
  - Next state is IDLE.
- Latency (request first high in cycle T, arbiter idle)
  - Read: m_ce at T+1, rdata captured at T+1+MEM_LAT, valid at T+2+MEM_LAT.
  - Write: m_ce/m_we at T+1, d_valid at T+2.
- Back-to-back spacing
  - Reads occupy MEM_LAT+3 cycles per transaction; writes occupy 3.
  - No overlap: at most one outstanding transaction.
- Latching and protocol violations
  - Inputs are latched at grant; address or data changes after grant are ignored.
  - If a requester deasserts req mid-transaction (protocol violation), the transaction still completes and valid still pulses.
- Output hold rules
  - Outside ISSUE, m_ce=0 and m_we=0; m_addr and m_wdata hold their last values.
  - i_valid and d_valid are never high in the same cycle.
  - rdata registers hold their value until the next capture.
- Counter width is clog2(MEM_LAT+1).
- Read-data routing: a d_we=0 load returns data on d_rdata only; i_rdata is untouched.

Test Plan:
- Single fetch (MEM_LAT=2): i_req=1, i_addr=0x40 at cycle 0; memory returns 0x12345678 → m_ce=1, m_addr=0x40, m_we=0 at cycle 1; i_valid=1 with i_rdata=0x12345678 at cycle 4; i_stall_req=1 for cycles 0–3 and 0 at cycle 4.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF at cycle 0 → m_ce=m_we=1, m_addr=0x100, m_wdata=0xDEADBEEF at cycle 1; d_valid=1 at cycle 2; i_valid stays 0.
- Tie after reset: i_req and d_req both high from cycle 0, both held until their valids → D is served first (d_valid at cycle 4), then I (m_ce at cycle 6, i_valid at cycle 9).
- Sustained contention: both requesters re-request immediately for 4 transactions → grant order D, I, D, I; no two m_ce pulses closer than 5 cycles.
- Reset mid-operation: assert rst_n=1 during WAIT of a fetch → next cycle all outputs 0 and state IDLE; no i_valid pulse ever appears for that fetch; a fresh request after reset completes normally.
- MEM_LAT=1 build: load d_addr=0x8, m_rdata=0xA5A5A5A5 → m_ce at cycle 1, d_valid with d_rdata=0xA5A5A5A5 at cycle 3.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/MEM arbiter for one shared single-port fixed-latency memory
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    output logic          i_stall_req,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall_req,
    output logic          m_ce,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          last_grant_d;
    logic          owner_d;
    logic          owner_we;
    logic [CW-1:0] cnt;
    logic          any_req;
    logic          grant_d;
    logic          grant_we;
    logic          wait_done;
    logic          m_ce_nxt;
    logic          m_we_nxt;
    logic          i_valid_nxt;
    logic          d_valid_nxt;

    // On a tie the requester that did not win last time gets the memory.
    assign any_req     = i_req | d_req;
    assign grant_d     = (i_req & d_req) ? ~last_grant_d : d_req;
    assign grant_we    = grant_d & d_we;
    assign wait_done   = (cnt == '0);
    assign i_stall_req = i_req & ~i_valid;
    assign d_stall_req = d_req & ~d_valid;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_ISSUE;
            S_ISSUE: next_state = owner_we ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_done) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes are computed from the upcoming state so they leave flops aligned to it.
    always_comb begin
        m_ce_nxt    = 1'b0;
        m_we_nxt    = 1'b0;
        i_valid_nxt = 1'b0;
        d_valid_nxt = 1'b0;
        if (next_state == S_ISSUE) begin
            m_ce_nxt = 1'b1;
            m_we_nxt = grant_we;
        end
        if (next_state == S_RESP) begin
            i_valid_nxt = ~owner_d;
            d_valid_nxt = owner_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            m_ce         <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            i_valid      <= 1'b0;
            d_valid      <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            last_grant_d <= 1'b0;
            owner_d      <= 1'b0;
            owner_we     <= 1'b0;
            cnt          <= '0;
        end else begin
            m_ce    <= m_ce_nxt;
            m_we    <= m_we_nxt;
            i_valid <= i_valid_nxt;
            d_valid <= d_valid_nxt;

            if (state == S_IDLE && any_req) begin
                owner_d      <= grant_d;
                owner_we     <= grant_we;
                last_grant_d <= grant_d;
                m_addr       <= grant_d ? d_addr : i_addr;
                if (grant_d) begin
                    m_wdata <= d_wdata;
                end
            end

            if (state == S_ISSUE) begin
                cnt <= CW'(MEM_LAT - 1);
            end else if (state == S_WAIT && !wait_done) begin
                cnt <= cnt - CW'(1);
            end

            // Read data lands in the owner's register only; the other side keeps its last value.
            if (state == S_WAIT && wait_done) begin
                if (owner_d) begin
                    d_rdata <= m_rdata;
                end else begin
                    i_rdata <= m_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
    localparam int MEM_LAT = 2;

    typedef struct {
        int          cyc;
        logic        we;
        logic        own_d;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        i_stall_req;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall_req;
    logic        m_ce;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;

    logic        rst_b = 1'b1;
    logic        d_req_b = 1'b0;
    logic [31:0] d_addr_b = '0;
    logic [31:0] i_rdata_b;
    logic        i_valid_b;
    logic        i_stall_req_b;
    logic [31:0] d_rdata_b;
    logic        d_valid_b;
    logic        d_stall_req_b;
    logic        m_ce_b;
    logic        m_we_b;
    logic [31:0] m_addr_b;
    logic [31:0] m_wdata_b;
    logic [31:0] m_rdata_b = '0;
    logic        done_b = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic mon_on = 1'b0;

    ev_t ce_q[$];
    ev_t v_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] env_mem [logic [31:0]];
    int          free_at = 0;
    logic        last_d = 1'b0;
    logic [31:0] exp_ird = '0;
    logic [31:0] exp_drd = '0;
    int          last_ce = -1;
    logic        last_ce_we = 1'b0;
    logic        rd_pend = 1'b0;
    int          rd_due = 0;
    logic [31:0] rd_data = '0;

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall_req(i_stall_req),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall_req(d_stall_req),
        .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_b),
        .i_req(1'b0), .i_addr(32'h0), .i_rdata(i_rdata_b), .i_valid(i_valid_b), .i_stall_req(i_stall_req_b),
        .d_req(d_req_b), .d_we(1'b0), .d_addr(d_addr_b), .d_wdata(32'h0),
        .d_rdata(d_rdata_b), .d_valid(d_valid_b), .d_stall_req(d_stall_req_b),
        .m_ce(m_ce_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        return {26'd0, w, 2'b00};
    endfunction

    // Monitor, memory environment and reference model, in that order, once per cycle.
    always @(negedge clk) begin
        ev_t  e;
        logic gd;
        logic exp_ce;
        logic exp_iv;
        logic exp_dv;
        if (mon_on) begin
            if (ce_q.size() > 0 && ce_q[0].cyc < cyc) begin
                check("mce_missing", 32'(ce_q[0].cyc), 32'(cyc));
                e = ce_q.pop_front();
            end
            exp_ce = (ce_q.size() > 0 && ce_q[0].cyc == cyc);
            check("m_ce", {31'd0, m_ce}, {31'd0, exp_ce});
            if (exp_ce) begin
                e = ce_q.pop_front();
                check("m_addr", m_addr, e.addr);
                check("m_we", {31'd0, m_we}, {31'd0, e.we});
                if (e.we) check("m_wdata", m_wdata, e.data);
                if (last_ce >= 0)
                    check("mce_spacing", 32'(cyc - last_ce), 32'((cyc - last_ce) >= (last_ce_we ? 3 : MEM_LAT + 3) ? cyc - last_ce : -1));
                last_ce    = cyc;
                last_ce_we = e.we;
            end else begin
                check("m_we_idle", {31'd0, m_we}, 32'd0);
            end

            if (v_q.size() > 0 && v_q[0].cyc < cyc) begin
                check("valid_missing", 32'(v_q[0].cyc), 32'(cyc));
                e = v_q.pop_front();
            end
            exp_iv = (v_q.size() > 0 && v_q[0].cyc == cyc && !v_q[0].own_d);
            exp_dv = (v_q.size() > 0 && v_q[0].cyc == cyc && v_q[0].own_d);
            check("i_valid", {31'd0, i_valid}, {31'd0, exp_iv});
            check("d_valid", {31'd0, d_valid}, {31'd0, exp_dv});
            if (exp_iv || exp_dv) begin
                e = v_q.pop_front();
                if (!e.we) begin
                    if (e.own_d) exp_drd = e.data;
                    else         exp_ird = e.data;
                end
            end
            check("i_rdata", i_rdata, exp_ird);
            check("d_rdata", d_rdata, exp_drd);
            check("i_stall_req", {31'd0, i_stall_req}, {31'd0, i_req & ~exp_iv});
            check("d_stall_req", {31'd0, d_stall_req}, {31'd0, d_req & ~exp_dv});
        end

        if (rd_pend && cyc == rd_due) begin
            m_rdata = rd_data;
            rd_pend = 1'b0;
        end else begin
            m_rdata = $urandom;
        end
        if (m_ce && !m_we) begin
            rd_pend = 1'b1;
            rd_due  = cyc + MEM_LAT;
            rd_data = env_mem.exists(m_addr) ? env_mem[m_addr] : init_word(m_addr);
        end
        if (m_ce && m_we) env_mem[m_addr] = m_wdata;

        if (rst_n) begin
            ce_q.delete();
            v_q.delete();
            free_at = cyc + 1;
            last_d  = 1'b0;
            exp_ird = '0;
            exp_drd = '0;
            last_ce = -1;
        end else if (cyc >= free_at && (i_req || d_req)) begin
            gd      = (i_req && d_req) ? !last_d : d_req;
            last_d  = gd;
            e.own_d = gd;
            e.we    = gd && d_we;
            e.addr  = gd ? d_addr : i_addr;
            e.data  = d_wdata;
            e.cyc   = cyc + 1;
            if (e.we) ref_mem[e.addr] = e.data;
            else      e.data = ref_mem.exists(e.addr) ? ref_mem[e.addr] : init_word(e.addr);
            ce_q.push_back(e);
            e.cyc   = e.we ? cyc + 2 : cyc + 2 + MEM_LAT;
            v_q.push_back(e);
            free_at = e.cyc + 1;
        end
    end

    task automatic req_i(input logic [31:0] a);
        int t;
        i_req  = 1'b1;
        i_addr = a;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!i_valid && t < 40);
        check("i_handshake", {31'd0, i_valid}, 32'd1);
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        int t;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!d_valid && t < 40);
        check("d_handshake", {31'd0, d_valid}, 32'd1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic loop_i(input int n);
        for (int k = 0; k < n; k++) begin
            req_i(rand_addr());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic loop_d(input int n);
        for (int k = 0; k < n; k++) begin
            req_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_ce"}, {31'd0, m_ce}, 32'd0);
        check({tag, "_m_we"}, {31'd0, m_we}, 32'd0);
        check({tag, "_m_addr"}, m_addr, 32'd0);
        check({tag, "_m_wdata"}, m_wdata, 32'd0);
        check({tag, "_i_valid"}, {31'd0, i_valid}, 32'd0);
        check({tag, "_d_valid"}, {31'd0, d_valid}, 32'd0);
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        ref_mem[32'h40] = 32'h1234_5678;
        env_mem[32'h40] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;

        // Tie straight after reset, then directed fetch/store/load.
        fork
            req_i(32'h44);
            req_d(1'b0, 32'h48, 32'h0);
        join
        idle(2);
        req_i(32'h40);
        idle(1);
        req_d(1'b1, 32'h100, 32'hDEAD_BEEF);
        req_d(1'b0, 32'h100, 32'h0);
        idle(2);

        // Load request dropped one cycle after grant, with the address changing underneath.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h20;
        idle(1);
        d_req  = 1'b0;
        d_addr = 32'h3C;
        idle(8);

        fork
            loop_i(14);
            loop_d(14);
        join
        idle(4);

        // Reset while a fetch sits in WAIT.
        i_req  = 1'b1;
        i_addr = 32'h80;
        idle(3);
        rst_n = 1'b1;
        i_req = 1'b0;
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        idle(10);
        req_i(32'h40);
        req_d(1'b0, 32'h100, 32'h0);
        idle(6);

        check("ce_q_drained", 32'(ce_q.size()), 32'd0);
        check("v_q_drained", 32'(v_q.size()), 32'd0);
        for (int k = 0; k < 200 && !done_b; k++) @(posedge clk);
        check("lat1_done", {31'd0, done_b}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // MEM_LAT=1 instance: single load, memory answers only in the cycle after m_ce.
    initial begin
        int   t0;
        int   ce_c;
        int   dv_c;
        logic saw_iv;
        ce_c   = -10;
        dv_c   = -10;
        saw_iv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b    = 1'b0;
        t0       = cyc;
        d_req_b  = 1'b1;
        d_addr_b = 32'h8;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            m_rdata_b = (cyc == ce_c + 1) ? 32'hA5A5_A5A5 : $urandom;
            if (m_ce_b) begin
                ce_c = cyc;
                check("lat1_m_addr", m_addr_b, 32'h8);
                check("lat1_m_we", {31'd0, m_we_b}, 32'd0);
            end
            if (d_valid_b) begin
                dv_c = cyc;
                check("lat1_d_rdata", d_rdata_b, 32'hA5A5_A5A5);
                d_req_b = 1'b0;
            end
            if (i_valid_b) saw_iv = 1'b1;
        end
        check("lat1_ce_cycle", 32'(ce_c), 32'(t0 + 1));
        check("lat1_valid_cycle", 32'(dv_c), 32'(t0 + 3));
        check("lat1_no_i_valid", {31'd0, saw_iv}, 32'd0);
        done_b = 1'b1;
    end
endmodule
